lcd_seg_streamer: RTL

LCD_SEG_STREAMER -- requirements
Module: lcd_seg_streamer

---
 rtl/lcd_seg_streamer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/lcd_seg_streamer.sv
// Streams a snapshot of NUM_DIGITS 7-segment patterns as character codes over a
// valid/ready handshake, with optional leading-zero suppression.
module lcd_seg_streamer #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  input  logic                    zero_blank,
  input  logic                    start,
  output logic [7:0]              char_out,
  output logic [3:0]              char_pos,
  output logic                    char_valid,
  input  logic                    char_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    invalid
);

  localparam int unsigned SEG_W    = 7 * NUM_DIGITS;
  localparam logic [3:0]  LAST_POS = 4'(NUM_DIGITS - 1);
  localparam logic [6:0]  ZERO_PAT = 7'b1111110;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t           r_state, w_state_n;
  logic [SEG_W-1:0] r_seg, w_seg_n;
  logic             r_zb, w_zb_n;
  logic             r_lead, w_lead_n;
  logic [3:0]       r_pos, w_pos_n;
  logic [7:0]       r_char, w_char_n;
  logic             r_valid, w_valid_n;
  logic             r_busy, w_busy_n;
  logic             r_done, w_done_n;
  logic             r_invalid, w_invalid_n;
  logic [9:0]       w_cur;
  logic             w_lead_after;
  logic [6:0]       w_dig [16];

  // Result: {undecodable, keeps leading-zero run alive, character code}
  function automatic logic [9:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: decode = {2'b01, 8'h30};
      7'b0110000: decode = {2'b00, 8'h31};
      7'b1101101: decode = {2'b00, 8'h32};
      7'b1111001: decode = {2'b00, 8'h33};
      7'b0110011: decode = {2'b00, 8'h34};
      7'b1011011: decode = {2'b00, 8'h35};
      7'b1011111: decode = {2'b00, 8'h36};
      7'b1110000: decode = {2'b00, 8'h37};
      7'b1111111: decode = {2'b00, 8'h38};
      7'b1111011: decode = {2'b00, 8'h39};
      7'b0000001: decode = {2'b00, 8'h2D};
      7'b0000000: decode = {2'b01, BLANK_CHAR};
      default:    decode = {2'b11, BLANK_CHAR};
    endcase
  endfunction

  function automatic logic [7:0] shown(input logic [6:0] seg, input logic zb,
                                       input logic lead, input logic last);
    logic [9:0] d;
    d = decode(seg);
    if (zb && lead && !last && (seg == ZERO_PAT)) shown = BLANK_CHAR;
    else                                          shown = d[7:0];
  endfunction

  // Fixed 16-entry view so a 4-bit position indexes it exactly
  for (genvar g = 0; g < 16; g++) begin : g_dig
    if (g < NUM_DIGITS) begin : g_used
      assign w_dig[g] = r_seg[7*g +: 7];
    end else begin : g_unused
      assign w_dig[g] = 7'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_seg     <= '0;
      r_zb      <= 1'b0;
      r_lead    <= 1'b0;
      r_pos     <= 4'd0;
      r_char    <= 8'h00;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_seg     <= w_seg_n;
      r_zb      <= w_zb_n;
      r_lead    <= w_lead_n;
      r_pos     <= w_pos_n;
      r_char    <= w_char_n;
      r_valid   <= w_valid_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_invalid <= w_invalid_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_seg_n      = r_seg;
    w_zb_n       = r_zb;
    w_lead_n     = r_lead;
    w_pos_n      = r_pos;
    w_char_n     = r_char;
    w_valid_n    = r_valid;
    w_busy_n     = r_busy;
    w_done_n     = 1'b0;
    w_invalid_n  = r_invalid;
    w_cur        = decode(w_dig[r_pos]);
    w_lead_after = r_lead & w_cur[8];
    case (r_state)
      S_IDLE: begin
        w_valid_n = 1'b0;
        w_busy_n  = 1'b0;
        if (start) begin
          w_state_n   = S_SEND;
          w_seg_n     = seg_in;
          w_zb_n      = zero_blank;
          w_lead_n    = 1'b1;
          w_pos_n     = 4'd0;
          w_char_n    = shown(seg_in[6:0], zero_blank, 1'b1, LAST_POS == 4'd0);
          w_valid_n   = 1'b1;
          w_busy_n    = 1'b1;
          w_invalid_n = 1'b0;
        end
      end
      S_SEND: begin
        if (char_ready) begin
          w_invalid_n = r_invalid | w_cur[9];
          w_lead_n    = w_lead_after;
          if (r_pos == LAST_POS) begin
            w_state_n = S_DONE;
            w_valid_n = 1'b0;
            w_done_n  = 1'b1;
          end else begin
            w_pos_n  = r_pos + 4'd1;
            w_char_n = shown(w_dig[r_pos + 4'd1], r_zb, w_lead_after,
                             (r_pos + 4'd1) == LAST_POS);
          end
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
        w_valid_n = 1'b0;
        w_busy_n  = 1'b0;
      end
      default: begin
        w_state_n = S_IDLE;
        w_valid_n = 1'b0;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  assign char_out   = r_char;
  assign char_pos   = r_pos;
  assign char_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign invalid    = r_invalid;

endmodule
